// File: rtl/vlsu_seg_splitter.sv
// Splits one vector load/store request into AXI INCR bursts that respect BoundBytes and MaxBeats.
// Optional statistics counters are built only when VLSU_SEG_STATS_EN is defined.
module vlsu_seg_splitter #(
   parameter int AddrWidth  = 32,
   parameter int LenWidth   = 16,
   parameter int BusBytes   = 16,
   parameter int MaxBeats   = 256,
   parameter int BoundBytes = 4096
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          req_valid_i,
   output logic                          req_ready_o,
   input  logic [AddrWidth-1:0]          req_addr_i,
   input  logic [LenWidth-1:0]           req_bytes_i,
   input  logic                          req_is_load_i,
   output logic                          meta_valid_o,
   input  logic                          meta_ready_i,
   output logic [AddrWidth-1:0]          meta_seg_addr_o,
   output logic [7:0]                    meta_txn_num_o,
   output logic [$clog2(BusBytes):0]     meta_lt_n_o,
   output logic                          meta_is_load_o,
   output logic                          meta_final_o,
   output logic                          busy_o,
   output logic [31:0]                   stat_req_o,
   output logic [31:0]                   stat_seg_o
);

   localparam int OffW = $clog2(BusBytes);
   localparam int BndW = $clog2(BoundBytes);
   localparam int CW   = LenWidth + 1;
   localparam int LtW  = OffW + 1;

   localparam logic STATE_IDLE  = 1'b0;
   localparam logic STATE_SPLIT = 1'b1;

   logic                 state_q, state_d;
   logic [AddrWidth-1:0] addr_q, addr_d;
   logic [LenWidth-1:0]  rem_q, rem_d;
   logic                 is_load_q, is_load_d;

   logic [CW-1:0] off_w, bnd_w, mx_w, rem_w, seg_w, end_w, last_w;
   logic          seg_final;
   logic          unused_hi;

   // Segment = min(remaining, bytes to boundary, bytes that fit in MaxBeats beats).
   always_comb begin
      off_w = CW'(addr_q[OffW-1:0]);
      bnd_w = CW'(BoundBytes) - CW'(addr_q[BndW-1:0]);
      mx_w  = CW'(MaxBeats * BusBytes) - off_w;
      rem_w = CW'(rem_q);
      seg_w = rem_w;
      if (bnd_w < seg_w) seg_w = bnd_w;
      if (mx_w < seg_w)  seg_w = mx_w;
      end_w = off_w + seg_w;
      last_w = end_w - CW'(1);
   end

   assign seg_final = (seg_w == rem_w);
   assign unused_hi = ^last_w[CW-1:OffW+8];

   assign req_ready_o     = (state_q == STATE_IDLE);
   assign meta_valid_o    = (state_q == STATE_SPLIT);
   assign busy_o          = (state_q != STATE_IDLE);
   assign meta_seg_addr_o = addr_q;
   // Index of the last byte, in beats, is exactly beats-1 (seg is never 0 in SPLIT).
   assign meta_txn_num_o  = last_w[OffW+7:OffW];
   assign meta_lt_n_o     = {1'b0, last_w[OffW-1:0]} + LtW'(1);
   assign meta_is_load_o  = is_load_q;
   assign meta_final_o    = seg_final;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      rem_d     = rem_q;
      is_load_d = is_load_q;
      case (state_q)
         STATE_IDLE: begin
            if (req_valid_i && (req_bytes_i != '0)) begin
               addr_d    = req_addr_i;
               rem_d     = req_bytes_i;
               is_load_d = req_is_load_i;
               state_d   = STATE_SPLIT;
            end
         end
         STATE_SPLIT: begin
            if (meta_ready_i) begin
               addr_d = addr_q + AddrWidth'(seg_w);
               rem_d  = rem_q - seg_w[LenWidth-1:0];
               if (seg_final) state_d = STATE_IDLE;
            end
         end
         default: state_d = STATE_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= STATE_IDLE;
         addr_q    <= '0;
         rem_q     <= '0;
         is_load_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         rem_q     <= rem_d;
         is_load_q <= is_load_d;
      end
   end

`ifdef VLSU_SEG_STATS_EN
   logic [31:0] stat_req_q, stat_seg_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stat_req_q <= '0;
         stat_seg_q <= '0;
      end else begin
         if (req_valid_i && req_ready_o)   stat_req_q <= stat_req_q + 32'd1;
         if (meta_valid_o && meta_ready_i) stat_seg_q <= stat_seg_q + 32'd1;
      end
   end

   assign stat_req_o = stat_req_q;
   assign stat_seg_o = stat_seg_q;
`else
   assign stat_req_o = '0;
   assign stat_seg_o = '0;
`endif

endmodule

// File: tb/tb_vlsu_seg_splitter.sv
// Bench for vlsu_seg_splitter: directed scenarios plus random requests against a segment-list model.
module tb_vlsu_seg_splitter;
   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic [31:0] req_addr_i = '0;
   logic [15:0] req_bytes_i = '0;
   logic        req_is_load_i = 1'b0;
   logic        meta_valid_o;
   logic        meta_ready_i = 1'b0;
   logic [31:0] meta_seg_addr_o;
   logic [7:0]  meta_txn_num_o;
   logic [4:0]  meta_lt_n_o;
   logic        meta_is_load_o;
   logic        meta_final_o;
   logic        busy_o;
   logic [31:0] stat_req_o;
   logic [31:0] stat_seg_o;

   int errors = 0;
   int checks = 0;
   int req_cnt = 0;
   int seg_cnt = 0;
   // {addr[31:0], txn_num[7:0], lt_n[4:0], final, is_load}
   logic [46:0] exp_q[$];

   vlsu_seg_splitter dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_addr_i(req_addr_i), .req_bytes_i(req_bytes_i), .req_is_load_i(req_is_load_i),
      .meta_valid_o(meta_valid_o), .meta_ready_i(meta_ready_i),
      .meta_seg_addr_o(meta_seg_addr_o), .meta_txn_num_o(meta_txn_num_o),
      .meta_lt_n_o(meta_lt_n_o), .meta_is_load_o(meta_is_load_o),
      .meta_final_o(meta_final_o), .busy_o(busy_o),
      .stat_req_o(stat_req_o), .stat_seg_o(stat_seg_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: walk the request byte by byte-range using the burst rules directly.
   task automatic model_push(input logic [31:0] a, input int unsigned bytes, input logic ld);
      logic [31:0] addr;
      int unsigned rem, off, bnd, mx, seg, beats, lt;
      logic fin;
      addr = a;
      rem  = bytes;
      while (rem > 0) begin
         off = addr % 16;
         bnd = 4096 - (addr % 4096);
         mx  = 256 * 16 - off;
         seg = rem;
         if (bnd < seg) seg = bnd;
         if (mx < seg) seg = mx;
         beats = (off + seg + 15) / 16;
         lt    = ((off + seg - 1) % 16) + 1;
         fin   = (seg == rem);
         exp_q.push_back({addr, 8'(beats - 1), 5'(lt), fin, ld});
         addr = addr + seg;
         rem  = rem - seg;
      end
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_ni = 1'b0;
      meta_ready_i = 1'b0;
      req_valid_i = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      req_cnt = 0;
      seg_cnt = 0;
      exp_q.delete();
   endtask

   // Returns at the negedge right after the accepting edge.
   task automatic send_req(input logic [31:0] a, input logic [15:0] b, input logic ld);
      int waitc;
      waitc = 0;
      @(negedge clk_i);
      while (!req_ready_o && waitc < 100) begin
         @(negedge clk_i);
         waitc++;
      end
      checks++;
      if (req_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL req_ready_wait: got %b want 1", req_ready_o);
      end
      req_valid_i = 1'b1;
      req_addr_i = a;
      req_bytes_i = b;
      req_is_load_i = ld;
      @(negedge clk_i);
      req_valid_i = 1'b0;
      req_cnt++;
      model_push(a, b, ld);
   endtask

   // Scoreboard: every cycle the presented segment must equal the head of exp_q.
   task automatic drain(input int rdy_pct, input int hold_first);
      int cyc;
      logic [46:0] act, e;
      cyc = 0;
      while (exp_q.size() > 0) begin
         if (cyc >= 5000) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d segments left", exp_q.size());
            break;
         end
         checks++;
         if (meta_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL meta_valid: got %b want 1 (%0d segments left)", meta_valid_o, exp_q.size());
            break;
         end
         act = {meta_seg_addr_o, meta_txn_num_o, meta_lt_n_o, meta_final_o, meta_is_load_o};
         e = exp_q[0];
         checks++;
         if (act !== e) begin
            errors++;
            $display("FAIL meta_seg: got addr=%h txn=%0d lt=%0d fin=%b ld=%b want addr=%h txn=%0d lt=%0d fin=%b ld=%b",
                     act[46:15], act[14:7], act[6:2], act[1], act[0], e[46:15], e[14:7], e[6:2], e[1], e[0]);
         end
         if (cyc < hold_first) meta_ready_i = 1'b0;
         else meta_ready_i = ($urandom_range(0, 99) < rdy_pct);
         if (meta_ready_i) begin
            void'(exp_q.pop_front());
            seg_cnt++;
         end
         @(negedge clk_i);
         cyc++;
      end
      exp_q.delete();
      meta_ready_i = 1'b0;
      checks++;
      if ({meta_valid_o, busy_o, req_ready_o} !== 3'b001) begin
         errors++;
         $display("FAIL after_final: got valid=%b busy=%b ready=%b want 0 0 1", meta_valid_o, busy_o, req_ready_o);
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({meta_valid_o, busy_o} !== 2'b00 || stat_req_o !== 32'd0 || stat_seg_o !== 32'd0) begin
         errors++;
         $display("FAIL reset_vals: got valid=%b busy=%b sreq=%0d sseg=%0d want 0 0 0 0",
                  meta_valid_o, busy_o, stat_req_o, stat_seg_o);
      end
      @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      checks++;
      if (req_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b want 1", req_ready_o);
      end
   endtask

   task automatic test_single_and_cross();
      send_req(32'h0000_1000, 16'd64, 1'b1);
      drain(100, 0);
      send_req(32'h0000_0FF8, 16'd32, 1'b0);
      drain(100, 0);
   endtask

   task automatic test_backpressure();
      send_req(32'h0000_2000, 16'd8192, 1'b1);
      drain(100, 5);
   endtask

   task automatic test_small_and_zero();
      send_req(32'h0000_0003, 16'd1, 1'b0);
      drain(100, 0);
      send_req(32'h0000_0040, 16'd0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({meta_valid_o, busy_o, req_ready_o} !== 3'b001) begin
            errors++;
            $display("FAIL zero_bytes: got valid=%b busy=%b ready=%b want 0 0 1", meta_valid_o, busy_o, req_ready_o);
         end
         @(negedge clk_i);
      end
   endtask

   task automatic test_reset_mid_split();
      send_req(32'h0000_2000, 16'd8192, 1'b1);
      meta_ready_i = 1'b0;
      checks++;
      if (meta_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL mid_split_valid: got %b want 1", meta_valid_o);
      end
      #2 rst_ni = 1'b0;
      #1;
      checks++;
      if ({meta_valid_o, busy_o} !== 2'b00 || stat_req_o !== 32'd0 || stat_seg_o !== 32'd0) begin
         errors++;
         $display("FAIL async_reset: got valid=%b busy=%b sreq=%0d sseg=%0d want 0 0 0 0",
                  meta_valid_o, busy_o, stat_req_o, stat_seg_o);
      end
      @(negedge clk_i);
      rst_ni = 1'b1;
      req_cnt = 0;
      seg_cnt = 0;
      exp_q.delete();
      meta_ready_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({meta_valid_o, req_ready_o} !== 2'b01) begin
            errors++;
            $display("FAIL post_reset_idle: got valid=%b ready=%b want 0 1", meta_valid_o, req_ready_o);
         end
         @(negedge clk_i);
      end
      meta_ready_i = 1'b0;
   endtask

   task automatic test_stats();
      int exp_req, exp_seg;
      do_reset();
      send_req(32'h0000_1000, 16'd64, 1'b1);
      drain(100, 0);
      send_req(32'h0000_0FF8, 16'd32, 1'b0);
      drain(100, 0);
`ifdef VLSU_SEG_STATS_EN
      exp_req = 2;
      exp_seg = 3;
`else
      exp_req = 0;
      exp_seg = 0;
`endif
      checks++;
      if (stat_req_o !== 32'(exp_req) || stat_seg_o !== 32'(exp_seg)) begin
         errors++;
         $display("FAIL stats_directed: got req=%0d seg=%0d want req=%0d seg=%0d", stat_req_o, stat_seg_o, exp_req, exp_seg);
      end
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [15:0] b;
      int exp_req, exp_seg;
      do_reset();
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 3))
            0: a = 32'hFFFF_F000 + 32'($urandom_range(0, 4095));
            1: a = 32'($urandom_range(0, 255)) * 4096 - 32'($urandom_range(0, 40));
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 4))
            0: b = 16'($urandom_range(0, 3));
            1: b = 16'($urandom_range(1, 64));
            2: b = 16'($urandom_range(4000, 9000));
            default: b = 16'($urandom);
         endcase
         send_req(a, b, 1'($urandom_range(0, 1)));
         drain(70, $urandom_range(0, 2));
      end
`ifdef VLSU_SEG_STATS_EN
      exp_req = req_cnt;
      exp_seg = seg_cnt;
`else
      exp_req = 0;
      exp_seg = 0;
`endif
      checks++;
      if (stat_req_o !== 32'(exp_req) || stat_seg_o !== 32'(exp_seg)) begin
         errors++;
         $display("FAIL stats_random: got req=%0d seg=%0d want req=%0d seg=%0d", stat_req_o, stat_seg_o, exp_req, exp_seg);
      end
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 4; n++) begin
         send_req(32'h0000_7F00 + 32'(n * 8), 16'd600, 1'b1);
         drain(100, 0);
      end
   endtask

   initial begin
      test_reset();
      test_single_and_cross();
      test_backpressure();
      test_small_and_zero();
      test_reset_mid_split();
      test_stats();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
